score_status_ctrl: RTL

//   Game-status controller feeding the Tetris side-panel UI renderer. Owns the score and

---
 rtl/score_status_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/score_status_ctrl.sv
// score_status_ctrl: game status FSM, score/highest registers and sequential BCD conversion
//   Clk, Reset (sync, active-low)          clock and reset
//   Start, Lines_valid, Lines_cleared[2:0], Top_out   game events from the playfield
//   Playing, Win, Lose                     game state flags
//   Score[6:0], Highest[6:0]               binary scores
//   Score_tens/ones, High_tens/ones [3:0]  BCD digits for the renderer
//   Digits_valid                           digits match Score/Highest
module score_status_ctrl #(
    parameter logic [6:0] WIN_SCORE = 7'd50,
    parameter logic [6:0] MAX_SCORE = 7'd99
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic       Lines_valid,
    input  logic [2:0] Lines_cleared,
    input  logic       Top_out,
    output logic       Playing,
    output logic       Win,
    output logic       Lose,
    output logic [6:0] Score,
    output logic [6:0] Highest,
    output logic [3:0] Score_tens,
    output logic [3:0] Score_ones,
    output logic [3:0] High_tens,
    output logic [3:0] High_ones,
    output logic       Digits_valid
);
    typedef enum logic [1:0] {IDLE, PLAY, WIN, LOSE} game_e;
    typedef enum logic [1:0] {CV_IDLE, CV_SCORE, CV_HIGH, CV_COMMIT} cv_e;
    game_e       state_q, state_d;
    cv_e         cv_q, cv_d;
    logic [6:0]  score_q, score_d, high_q, high_d, hsnap_q, hsnap_d;
    logic [14:0] sr_q, sr_d, sr_step;
    logic [7:0]  sbcd_q, sbcd_d, sdig_q, sdig_d, hdig_q, hdig_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        req_q, req_d, dv_q, dv_d;
    logic [3:0]  pts;
    logic [7:0]  sum;
    logic [6:0]  sat;
    logic        add, changed, commit;

    // One double-dabble step: add 3 to any BCD digit >= 5, then shift left.
    function automatic logic [14:0] dd_step(input logic [14:0] v);
        logic [3:0] t, o;
        t = (v[14:11] >= 4'd5) ? v[14:11] + 4'd3 : v[14:11];
        o = (v[10:7] >= 4'd5) ? v[10:7] + 4'd3 : v[10:7];
        return {t[2:0], o, v[6:0], 1'b0};
    endfunction

    always_comb begin
        pts = (Lines_cleared == 3'd0) ? 4'd0 :
              (Lines_cleared == 3'd1) ? 4'd1 :
              (Lines_cleared == 3'd2) ? 4'd3 :
              (Lines_cleared == 3'd3) ? 4'd5 : 4'd8;
        // 8-bit sum so an overflow past MAX_SCORE is seen before saturating
        sum = {1'b0, score_q} + {4'd0, pts};
        sat = (sum > {1'b0, MAX_SCORE}) ? MAX_SCORE : sum[6:0];
        add = (state_q == PLAY) && Lines_valid;
        state_d = state_q;
        score_d = score_q;
        if (state_q != PLAY) begin
            if (Start) begin
                state_d = PLAY;
                score_d = '0;
            end
        end else begin
            score_d = add ? sat : score_q;
            state_d = (add && sat >= WIN_SCORE) ? WIN : Top_out ? LOSE : PLAY;
        end
        high_d  = (state_q == PLAY && state_d != PLAY && score_d > high_q) ? score_d : high_q;
        changed = (score_d != score_q) || (high_d != high_q);
    end

    always_comb begin
        sr_step = dd_step(sr_q);
        cv_d    = cv_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        hsnap_d = hsnap_q;
        sbcd_d  = sbcd_q;
        sdig_d  = sdig_q;
        hdig_d  = hdig_q;
        commit  = 1'b0;
        case (cv_q)
            CV_IDLE: if (req_q) begin
                cv_d    = CV_SCORE;
                sr_d    = {8'd0, score_q};
                hsnap_d = high_q;
                cnt_d   = '0;
            end
            CV_SCORE: begin
                cnt_d = cnt_q + 3'd1;
                sr_d  = sr_step;
                if (cnt_q == 3'd6) begin
                    // park the score digits until the highest-score pass finishes
                    cv_d   = CV_HIGH;
                    sbcd_d = sr_step[14:7];
                    sr_d   = {8'd0, hsnap_q};
                    cnt_d  = '0;
                end
            end
            CV_HIGH: begin
                cnt_d = cnt_q + 3'd1;
                sr_d  = sr_step;
                if (cnt_q == 3'd6) cv_d = CV_COMMIT;
            end
            CV_COMMIT: begin
                cv_d   = CV_IDLE;
                sdig_d = sbcd_q;
                hdig_d = sr_q[14:7];
                commit = 1'b1;
            end
        endcase
        // a change seen mid-run is remembered and triggers a fresh run after commit
        req_d = changed || (req_q && cv_q != CV_IDLE);
        dv_d  = changed ? 1'b0 : (commit && !req_q) ? 1'b1 : dv_q;
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= IDLE;
            cv_q    <= CV_IDLE;
            score_q <= '0;
            high_q  <= '0;
            hsnap_q <= '0;
            sr_q    <= '0;
            sbcd_q  <= '0;
            sdig_q  <= '0;
            hdig_q  <= '0;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            dv_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cv_q    <= cv_d;
            score_q <= score_d;
            high_q  <= high_d;
            hsnap_q <= hsnap_d;
            sr_q    <= sr_d;
            sbcd_q  <= sbcd_d;
            sdig_q  <= sdig_d;
            hdig_q  <= hdig_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            dv_q    <= dv_d;
        end
    end

    assign Playing      = state_q == PLAY;
    assign Win          = state_q == WIN;
    assign Lose         = state_q == LOSE;
    assign Score        = score_q;
    assign Highest      = high_q;
    assign Score_tens   = sdig_q[7:4];
    assign Score_ones   = sdig_q[3:0];
    assign High_tens    = hdig_q[7:4];
    assign High_ones    = hdig_q[3:0];
    assign Digits_valid = dv_q;
endmodule
